// File: rtl/sincos_pkg.sv
// Shared constants and types for the sincos lookup scheduler.
package sincos_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COS  = 2'd1,
        SIN  = 2'd2
    } state_t;

    // Tag word: valid at bit 0, is_sin at bit 1, channel from bit 2 up.
    localparam int TAG_V  = 0;
    localparam int TAG_S  = 1;
    localparam int TAG_CH = 2;

    function automatic int unsigned quarter(input int nba);
        return 32'd1 << (nba - 2);
    endfunction

    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sincos_if.sv
// Request, shared-pipeline and result signals of the sincos scheduler.
interface sincos_if #(
    parameter int NCH = 4,
    parameter int NBA = 22,
    parameter int NBO = 18
);
    import sincos_pkg::*;

    localparam int CHW = chw(NCH);

    logic [NCH-1:0]        req_valid;
    logic [NCH*NBA-1:0]    req_angle;
    logic [NCH-1:0]        req_ready;
    logic                  pl_valid;
    logic [NBA-1:0]        pl_angle;
    logic signed [NBO-1:0] pl_result;
    logic                  res_valid;
    logic [CHW-1:0]        res_ch;
    logic signed [NBO-1:0] res_cos;
    logic signed [NBO-1:0] res_sin;

    modport master (
        output req_valid, req_angle, pl_result,
        input  req_ready, pl_valid, pl_angle,
        input  res_valid, res_ch, res_cos, res_sin
    );

    modport slave (
        input  req_valid, req_angle, pl_result,
        output req_ready, pl_valid, pl_angle,
        output res_valid, res_ch, res_cos, res_sin
    );

endinterface

// File: rtl/sincos_sched_rr_arb.sv
// Round-robin arbiter: grants the first requester after the last grant.
module rr_arb
    import sincos_pkg::*;
#(
    parameter int N = 4,
    localparam int W = chw(N)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    logic [W-1:0] last;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last) + i) % N]) begin
                idx = W'((int'(last) + i) % N);
            end
        end
        gnt = '0;
        gnt[idx] = |req;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last <= W'(N - 1);
        end else if (en && |req) begin
            last <= idx;
        end
    end

endmodule

// File: rtl/sincos_sched.sv
// Time-shares one cosine pipeline among NCH requesters, issuing
// cos(x) then cos(x - quarter) and pairing the results per channel.
module sincos_sched
    import sincos_pkg::*;
#(
    parameter int NCH = 4,
    parameter int NBA = 22,
    parameter int NBO = 18,
    parameter int LAT = 9
) (
    input logic     clock,
    input logic     reset_n,
    input logic     clr,
    sincos_if.slave bus
);

    localparam int CHW = chw(NCH);
    localparam int TW  = CHW + 2;
    localparam logic [NBA-1:0] QTR = NBA'(quarter(NBA));

    state_t                state;
    state_t                nxt;
    logic                  en;
    logic                  accept;
    logic [NCH-1:0]        gnt;
    logic [CHW-1:0]        idx;
    logic [NBA-1:0]        sel_angle;
    logic [NBA-1:0]        x;
    logic [CHW-1:0]        cur_ch;
    logic                  iss_sin;
    logic [TW-1:0]         tag [LAT];
    logic [TW-1:0]         tout;
    logic signed [NBO-1:0] hold;

    rr_arb #(.N(NCH)) u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .en      (en),
        .gnt     (gnt),
        .idx     (idx)
    );

    assign en = reset_n && !clr && (state == IDLE || state == SIN);
    assign accept = en && (|gnt);
    assign sel_angle = bus.req_angle[int'(idx)*NBA +: NBA];
    assign tout = tag[LAT-1];

    always_comb begin
        bus.req_ready = accept ? gnt : '0;
        nxt = state;
        unique case (state)
            IDLE:    if (accept) nxt = COS;
            COS:     nxt = SIN;
            SIN:     nxt = accept ? COS : IDLE;
            default: nxt = IDLE;
        endcase
        if (clr) nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nxt;
    end

    // Issue registers carry the lookup for the state being entered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x            <= '0;
            cur_ch       <= '0;
            iss_sin      <= 1'b0;
            bus.pl_valid <= 1'b0;
            bus.pl_angle <= '0;
        end else begin
            if (accept) begin
                x      <= sel_angle;
                cur_ch <= idx;
            end
            bus.pl_valid <= (nxt != IDLE);
            iss_sin      <= (nxt == SIN);
            if (nxt == COS)      bus.pl_angle <= sel_angle;
            else if (nxt == SIN) bus.pl_angle <= x - QTR;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) tag[i] <= '0;
        end else begin
            tag[0] <= {cur_ch, iss_sin, bus.pl_valid & ~clr};
            for (int i = 1; i < LAT; i++) begin
                tag[i] <= {tag[i-1][TW-1:1], tag[i-1][TAG_V] & ~clr};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold          <= '0;
            bus.res_valid <= 1'b0;
            bus.res_ch    <= '0;
            bus.res_cos   <= '0;
            bus.res_sin   <= '0;
        end else begin
            bus.res_valid <= 1'b0;
            if (tout[TAG_V] && !clr) begin
                if (tout[TAG_S]) begin
                    bus.res_valid <= 1'b1;
                    bus.res_ch    <= tout[TAG_CH +: CHW];
                    bus.res_cos   <= hold;
                    bus.res_sin   <= bus.pl_result;
                end else begin
                    hold <= bus.pl_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_sincos_sched.sv
// Directed bench with a delay-line pipeline model and result scoreboard.
module tb_sincos_sched;
    import sincos_pkg::*;

    localparam int NCH = 4;
    localparam int NBA = 22;
    localparam int NBO = 18;
    localparam int LAT = 9;
    localparam logic [NBA-1:0] QTR = 22'h100000;

    typedef struct {
        int             ch;
        logic [NBO-1:0] c;
        logic [NBO-1:0] s;
        int             cyc;
    } exp_t;

    logic   clock = 1'b0;
    logic   reset_n;
    logic   clr;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    exp_t   sb [$];
    logic [NBA-1:0] pipe [LAT];

    sincos_if #(.NCH(NCH), .NBA(NBA), .NBO(NBO)) bus ();

    sincos_sched #(.NCH(NCH), .NBA(NBA), .NBO(NBO), .LAT(LAT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (clr),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        pipe[0] <= bus.pl_angle;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.pl_result = pipe[LAT-1][NBO-1:0];

    function automatic logic [NBO-1:0] model(input logic [NBA-1:0] a);
        return a[NBO-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        logic [NBA-1:0] a;
        if (bus.res_valid) begin
            if (sb.size() == 0) begin
                chk("stray_res", {63'b0, bus.res_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("res_ch", bus.res_ch, e.ch);
                chk("res_cos", $unsigned(bus.res_cos), e.c);
                chk("res_sin", $unsigned(bus.res_sin), e.s);
                chk("res_cycle", cyc, e.cyc);
            end
        end
        if (!reset_n || clr) sb.delete();
        for (int c = 0; c < NCH; c++) begin
            if (bus.req_ready[c]) begin
                a     = bus.req_angle[c*NBA +: NBA];
                e.ch  = c;
                e.c   = model(a);
                e.s   = model(a - QTR);
                e.cyc = cyc + LAT + 3;
                sb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tab_step(input string tag, input logic [3:0] v,
                            input logic [3:0] e);
        step();
        bus.req_valid = v;
        #1;
        chk(tag, bus.req_ready, e);
    endtask

    task automatic req1(input int ch, input logic [NBA-1:0] a);
        int n = 0;
        bus.req_angle[ch*NBA +: NBA] = a;
        bus.req_valid[ch] = 1'b1;
        #1;
        while (!bus.req_ready[ch] && n < 20) begin
            step();
            #1;
            n++;
        end
        chk("req1_accept", bus.req_ready[ch], 1);
        step();
        bus.req_valid[ch] = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        chk(tag, sb.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pl_valid"}, bus.pl_valid, 0);
        chk({tag, "_pl_angle"}, bus.pl_angle, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_ch"}, bus.res_ch, 0);
        chk({tag, "_res_cos"}, $unsigned(bus.res_cos), 0);
        chk({tag, "_res_sin"}, $unsigned(bus.res_sin), 0);
        chk({tag, "_req_ready"}, bus.req_ready, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        clr = 1'b0;
        bus.req_valid = '0;
        bus.req_angle = '0;
        step();
        step();
        chk_zero("reset");
        #2 reset_n = 1'b1;

        // All four channels continuously valid from a fresh pointer.
        bus.req_angle = {22'h3FFFF0, 22'h2F0F0F, 22'h155555, 22'h0ABCDE};
        for (int i = 0; i <= 9; i++) begin
            logic [3:0] e;
            e = (i % 2 == 0 && i <= 8) ? 4'(1 << ((i / 2) % 4)) : 4'd0;
            tab_step("rr_all", (i <= 8) ? 4'hF : 4'h0, e);
            if (i >= 1) chk("rr_pl_valid", bus.pl_valid, 1);
        end
        step();
        chk("rr_pl_valid_last", bus.pl_valid, 1);
        step();
        chk("rr_pl_idle", bus.pl_valid, 0);
        drain("drain_rr");

        // Single request at angle zero: sin angle wraps to 3/4 turn.
        step();
        bus.req_angle[0 +: NBA] = 22'h000000;
        bus.req_valid = 4'b0001;
        #1;
        chk("t1_ready", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = 4'b0000;
        chk("t1_cos_valid", bus.pl_valid, 1);
        chk("t1_cos_angle", bus.pl_angle, 22'h000000);
        step();
        chk("t1_sin_valid", bus.pl_valid, 1);
        chk("t1_sin_angle", bus.pl_angle, 22'h300000);
        step();
        chk("t1_idle", bus.pl_valid, 0);
        drain("drain_t1");

        // Pointer at 2; channels 2 and 3 together, then angle edges.
        req1(2, 22'h000123);
        bus.req_angle[2*NBA +: NBA] = 22'h100000;
        bus.req_angle[3*NBA +: NBA] = 22'h3FFFFF;
        bus.req_valid = 4'b1100;
        step();
        chk("t3_first", bus.req_ready, 4'b1000);
        step();
        bus.req_valid = 4'b0100;
        chk("t3_cos3", bus.pl_angle, 22'h3FFFFF);
        step();
        chk("t3_second", bus.req_ready, 4'b0100);
        chk("t3_sin3", bus.pl_angle, 22'h2FFFFF);
        step();
        bus.req_valid = 4'b0000;
        chk("t3_cos2", bus.pl_angle, 22'h100000);
        step();
        chk("t3_sin2", bus.pl_angle, 22'h000000);
        drain("drain_t3");

        // Flush in the SIN cycle of channel 1 with earlier pairs in flight.
        req1(0, 22'h011111);
        req1(2, 22'h022222);
        req1(3, 22'h033333);
        req1(1, 22'h044444);
        step();
        clr = 1'b1;
        bus.req_angle[2*NBA +: NBA] = 22'h2A5A5A;
        bus.req_valid = 4'b0100;
        #1;
        chk("clr_block", bus.req_ready, 4'b0000);
        step();
        clr = 1'b0;
        #1;
        chk("clr_pl_valid", bus.pl_valid, 0);
        chk("clr_next_ready", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = 4'b0000;
        drain("drain_clr");

        // Asynchronous reset in the middle of a stream.
        req1(3, 22'h2ABCDE);
        drain("drain_pre_rst");
        bus.req_angle[0 +: NBA] = 22'h0C0FFE;
        bus.req_angle[NBA +: NBA] = 22'h1BEEF1;
        bus.req_valid = 4'b0011;
        repeat (5) step();
        #3 reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        bus.req_valid = 4'b0000;
        step();
        step();
        #3 reset_n = 1'b1;
        tab_step("rst_prio", 4'b0011, 4'b0001);
        tab_step("rst_cos", 4'b0010, 4'b0000);
        tab_step("rst_ch1", 4'b0010, 4'b0010);
        tab_step("rst_end", 4'b0000, 4'b0000);
        drain("drain_rst");

        // Channel 1 gaps for one accept slot while channel 0 stays valid.
        bus.req_angle[0 +: NBA] = 22'h155555;
        bus.req_angle[NBA +: NBA] = 22'h0F0F0F;
        tab_step("gap_0", 4'b0011, 4'b0001);
        tab_step("gap_1", 4'b0011, 4'b0000);
        tab_step("gap_2", 4'b0011, 4'b0010);
        tab_step("gap_3", 4'b0001, 4'b0000);
        tab_step("gap_4", 4'b0001, 4'b0001);
        tab_step("gap_5", 4'b0011, 4'b0000);
        tab_step("gap_6", 4'b0011, 4'b0010);
        tab_step("gap_7", 4'b0011, 4'b0000);
        tab_step("gap_8", 4'b0011, 4'b0001);
        tab_step("gap_9", 4'b0000, 4'b0000);
        drain("drain_gap");

        repeat (LAT + 6) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sincos_sched.md
Name: sincos_sched

Overview:
- Round-robin scheduler that time-shares one cosine lookup pipeline (angle ROM plus the interpolating cosine DSP stage) among NCH phase requesters.
- For each accepted angle it issues two lookups on consecutive cycles: cos(x), then cos(x − quarter turn), which equals sin(x).
- It tracks in-flight lookups through the fixed-latency pipeline with a tag delay line and returns the paired cos/sin result tagged with the channel number.
- It sits between the NCO phase accumulators and the shared sincos datapath.

Parameters:
- NCH, 4, number of requesting channels (2..16).
- NBA, 22, angle width in bits; full turn = 2^NBA.
- NBO, 18, result width from the pipeline (signed).
- LAT, 9, cycles from pl_valid high with pl_angle to the matching value on pl_result (ROM plus cosine stage).
- Local CHW = clog2(NCH), minimum 1.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; discards in-flight lookups.
- req_valid  in  NCH  per-channel request.
- req_angle  in  NCH*NBA  channel i angle at bits [i*NBA +: NBA]; must be held while req_valid is high and req_ready is low.
- req_ready  out  NCH  one-hot accept strobe (combinational).
- pl_valid  out  1  lookup issued this cycle.
- pl_angle  out  NBA  angle to the shared pipeline.
- pl_result  in  NBO  signed pipeline output; meaningful LAT cycles after the issue.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  CHW  channel of the result.
- res_cos  out  NBO  signed cos(x).
- res_sin  out  NBO  signed sin(x).

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE; round-robin pointer is set so channel 0 has highest priority.
  - Tag line is cleared.
  - pl_valid = 0, pl_angle = 0, res_valid = 0, res_ch = 0, res_cos = 0, res_sin = 0; req_ready = 0.
- FSM states:
  - IDLE: pipeline free.
  - COS: issuing the cos lookup.
  - SIN: issuing the sin lookup.
- Acceptance:
  - Allowed only in IDLE or SIN, when clr is low and at least one req_valid is high.
  - The rr_arb grant goes to the first requesting channel after the last granted one (modulo NCH).
  - req_ready for that channel is high in that cycle; the angle is latched; next state is COS.
  - With no request, IDLE stays IDLE and SIN goes to IDLE.
- COS: pl_valid = 1, pl_angle = latched x; next state is SIN.
- SIN: pl_valid = 1, pl_angle = (x − 2^(NBA−2)) mod 2^NBA, wrapping at zero (e.g. 0 → 3·2^(NBA−2)). Acceptance may occur in the same cycle.
- Throughput: one request every 2 cycles, continuously; no idle cycle between back-to-back requests.
- pl_valid and pl_angle are registered. For an accept in cycle k, COS is issued in cycle k+1 and SIN in cycle k+2.
- Tag line:
  - LAT-deep shift register of {valid, is_sin, ch}, loaded from the registered issue.
  - Its output aligns with pl_result.
  - When a cos tag emerges, pl_result is captured into a cos hold register.
  - When a sin tag emerges, the registered outputs take res_cos = hold, res_sin = pl_result, res_ch = tag ch, res_valid = 1 for one cycle.
  - res_valid therefore rises at cycle k+LAT+3.
- Output holding: no output backpressure. res_cos, res_sin and res_ch hold their values until the next result; res_valid pulses.
- clr:
  - Zeroes all tag valid bits, forces the FSM to IDLE, clears pl_valid the next cycle, and blocks acceptance that cycle.
  - Results already registered stay; no result from a pre-clr issue is ever reported.
  - A half-issued pair (COS done, SIN pending) is dropped. The request was already acknowledged and is not retried.
- Reset mid-operation: identical drop semantics, asynchronous.
- Channel arbitration:
  - Channels with req_valid low are skipped with no pointer update.
  - A single requester is served every 2 cycles.
  - A request held valid across an accept is taken again as a new request; requesters deassert after req_ready.
- Width rules: angle subtraction is unsigned NBA-bit modulo. Results pass through unmodified (signed NBO).

Decomposition:
- Package sincos_pkg:
  - QUARTER = 2^(NBA−2) as a function of NBA.
  - FSM state encodings IDLE/COS/SIN.
  - Tag field layout (valid, is_sin, ch).
- Sub-module rr_arb:
  - Parameter N.
  - Inputs: req[N], en.
  - Outputs: one-hot gnt[N], encoded index.
  - Updates its pointer only when en and a grant occurs.

Test Plan (NBA=22, LAT=9; the bench pipeline model returns pl_result = low NBO bits of the angle delayed LAT):
- Channel 0 requests x=0x000000 at cycle k → pl_angle 0x000000 at k+1 and 0x300000 at k+2; res_valid at k+12 with res_ch=0, res_cos=model(0x000000), res_sin=model(0x300000).
- All 4 channels request continuously → grants 0,1,2,3,0 on cycles k, k+2, k+4, k+6, k+8; pl_valid high every cycle from k+1; res_valid every 2 cycles in channel order.
- Channel 2 x=0x100000 and channel 3 x=0x3FFFFF simultaneously, pointer at 2 → channel 3 granted first; sin angles 0x3FFFFF−0x100000=0x2FFFFF and 0x100000−0x100000=0x000000.
- clr asserted in the SIN cycle of a channel-1 request with 3 earlier results in flight → no res_valid for any pre-clr issue; the next request after clr returns after exactly LAT+3 cycles.
- reset_n pulsed low asynchronously mid-stream → all outputs 0 immediately; after release, channel 0 has priority and the first result is correct.
- Requester 1 drops req_valid for one cycle between requests while channel 0 is continuously valid → channel 0 is served back-to-back, channel 1 is picked at the first accept slot after it reasserts.
